// File: rtl/fetch_fd.sv
// Fetch stage and F/D pipeline register: owns the PC, drives the instruction-memory address,
// and hands {IR, PC+1, valid} to decode while handling stalls, redirects and memory wait cycles.
//
// state   | meaning
// BOOT    | first cycle after reset; F/D gets a bubble, PC holds
// RUN     | normal fetch; last cycle accepted, stalled or flushed
// WAIT    | instruction memory not ready last cycle; bubble issued
module fetch_fd #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  NOP      = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] fd_ir,
  output logic [DATA_W-1:0] fd_pc,
  output logic              fd_valid,
  output logic              fetch_busy,
  output logic [31:0]       fetched_cnt,
  output logic [31:0]       bubble_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] fd_ir_q, fd_ir_d;
  logic [DATA_W-1:0] fd_pc_q, fd_pc_d;
  logic              fd_valid_q, fd_valid_d;
  logic [31:0]       fetched_cnt_q, fetched_cnt_d;
  logic [31:0]       bubble_cnt_q, bubble_cnt_d;
  logic [DATA_W-1:0] pc_inc;

  assign pc_inc = pc_q + {{(DATA_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fd_ir_d       = fd_ir_q;
    fd_pc_d       = fd_pc_q;
    fd_valid_d    = fd_valid_q;
    fetched_cnt_d = fetched_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (flush || state_q == ST_BOOT || (!stall && !imem_valid)) begin
      fd_ir_d      = NOP;
      fd_pc_d      = '0;
      fd_valid_d   = 1'b0;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    if (flush) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else if (stall) begin
      state_d = state_q;
    end else if (!imem_valid) begin
      state_d = ST_WAIT;
    end else begin
      fd_ir_d       = imem_rdata;
      fd_pc_d       = pc_inc;
      fd_valid_d    = 1'b1;
      pc_d          = pc_inc;
      fetched_cnt_d = fetched_cnt_q + 32'd1;
      state_d       = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fd_ir_q       <= NOP;
      fd_pc_q       <= '0;
      fd_valid_q    <= 1'b0;
      fetched_cnt_q <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fd_ir_q       <= fd_ir_d;
      fd_pc_q       <= fd_pc_d;
      fd_valid_q    <= fd_valid_d;
      fetched_cnt_q <= fetched_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign fd_ir       = fd_ir_q;
  assign fd_pc       = fd_pc_q;
  assign fd_valid    = fd_valid_q;
  assign fetch_busy  = (state_q == ST_WAIT);
  assign fetched_cnt = fetched_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_fd.sv
// Directed bench for fetch_fd: each step drives one cycle of inputs and queues the
// hand-computed post-edge outputs; an independent monitor pops and compares them.
module tb_fetch_fd;

  logic        clk = 1'b0;
  logic        clr, stall, flush, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic [31:0] imem_addr, fd_ir, fd_pc, fetched_cnt, bubble_cnt;
  logic        fd_valid, fetch_busy;

  fetch_fd #(.DATA_W(32), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk         (clk),
    .clr         (clr),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .fd_ir       (fd_ir),
    .fd_pc       (fd_pc),
    .fd_valid    (fd_valid),
    .fetch_busy  (fetch_busy),
    .fetched_cnt (fetched_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] due;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        v;
    logic        busy;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned vec_id   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation on the falling edge after its due posedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (imem_addr !== e.addr || fd_ir !== e.ir || fd_pc !== e.pc || fd_valid !== e.v ||
          fetch_busy !== e.busy || fetched_cnt !== e.fcnt || bubble_cnt !== e.bcnt) begin
        failures++;
        $display("FAIL vec%0d: got addr=%h ir=%h pc=%h v=%b busy=%b fcnt=%0d bcnt=%0d, expected addr=%h ir=%h pc=%h v=%b busy=%b fcnt=%0d bcnt=%0d",
                 e.id, imem_addr, fd_ir, fd_pc, fd_valid, fetch_busy, fetched_cnt, bubble_cnt,
                 e.addr, e.ir, e.pc, e.v, e.busy, e.fcnt, e.bcnt);
      end
    end
  end

  task automatic step(input logic c, input logic s, input logic f, input logic [31:0] rpc,
                      input logic iv, input logic [31:0] rd,
                      input logic [31:0] e_addr, input logic [31:0] e_ir, input logic [31:0] e_pc,
                      input logic e_v, input logic e_busy, input logic [31:0] e_f,
                      input logic [31:0] e_b);
    exp_t e;
    @(negedge clk);
    clr = c; stall = s; flush = f; redirect_pc = rpc; imem_valid = iv; imem_rdata = rd;
    e.id = vec_id; e.due = cyc + 1; e.addr = e_addr; e.ir = e_ir; e.pc = e_pc;
    e.v = e_v; e.busy = e_busy; e.fcnt = e_f; e.bcnt = e_b;
    sb.push_back(e);
    vec_id++;
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0; imem_valid = 1'b0; imem_rdata = '0;

    //    clr stl fls rpc           iv   rdata        addr          ir     fd_pc  v  busy f  b
    // reset held two cycles, then BOOT bubble, then first fetch
    step(1, 0, 0, 32'h0,        0, 32'h0,   32'h0,  32'h0,  32'h0,  0, 0, 0, 0);
    step(1, 0, 0, 32'h0,        1, 32'h11,  32'h0,  32'h0,  32'h0,  0, 0, 0, 0);
    step(0, 0, 0, 32'h0,        1, 32'h11,  32'h0,  32'h0,  32'h0,  0, 0, 0, 1);
    step(0, 0, 0, 32'h0,        1, 32'h11,  32'h1,  32'h11, 32'h1,  1, 0, 1, 1);
    // streaming fetch
    step(0, 0, 0, 32'h0,        1, 32'h22,  32'h2,  32'h22, 32'h2,  1, 0, 2, 1);
    step(0, 0, 0, 32'h0,        1, 32'h33,  32'h3,  32'h33, 32'h3,  1, 0, 3, 1);
    step(0, 0, 0, 32'h0,        1, 32'h44,  32'h4,  32'h44, 32'h4,  1, 0, 4, 1);
    step(0, 0, 0, 32'h0,        1, 32'h55,  32'h5,  32'h55, 32'h5,  1, 0, 5, 1);
    // stall two cycles at pc=5, then fetch addr 5
    step(0, 1, 0, 32'h0,        1, 32'h66,  32'h5,  32'h55, 32'h5,  1, 0, 5, 1);
    step(0, 1, 0, 32'h0,        1, 32'h66,  32'h5,  32'h55, 32'h5,  1, 0, 5, 1);
    step(0, 0, 0, 32'h0,        1, 32'h66,  32'h6,  32'h66, 32'h6,  1, 0, 6, 1);
    // flush beats stall
    step(0, 1, 1, 32'h40,       1, 32'h77,  32'h40, 32'h0,  32'h0,  0, 0, 6, 2);
    step(0, 0, 0, 32'h0,        1, 32'h80,  32'h41, 32'h80, 32'h41, 1, 0, 7, 2);
    // redirect to 8, then memory not ready three cycles
    step(0, 0, 1, 32'h8,        1, 32'h88,  32'h8,  32'h0,  32'h0,  0, 0, 7, 3);
    step(0, 0, 0, 32'h0,        0, 32'hDEAD,32'h8,  32'h0,  32'h0,  0, 1, 7, 4);
    step(0, 0, 0, 32'h0,        0, 32'hDEAD,32'h8,  32'h0,  32'h0,  0, 1, 7, 5);
    step(0, 0, 0, 32'h0,        0, 32'hDEAD,32'h8,  32'h0,  32'h0,  0, 1, 7, 6);
    step(0, 0, 0, 32'h0,        1, 32'h99,  32'h9,  32'h99, 32'h9,  1, 0, 8, 6);
    // WAIT again, stall inside WAIT holds everything, then clr mid-WAIT
    step(0, 0, 0, 32'h0,        0, 32'h0,   32'h9,  32'h0,  32'h0,  0, 1, 8, 7);
    step(0, 0, 0, 32'h0,        0, 32'h0,   32'h9,  32'h0,  32'h0,  0, 1, 8, 8);
    step(0, 1, 0, 32'h0,        0, 32'h0,   32'h9,  32'h0,  32'h0,  0, 1, 8, 8);
    step(1, 0, 0, 32'h0,        0, 32'h0,   32'h0,  32'h0,  32'h0,  0, 0, 0, 0);
    // BOOT bubble even with memory not ready, then a fetch
    step(0, 0, 0, 32'h0,        0, 32'h0,   32'h0,  32'h0,  32'h0,  0, 0, 0, 1);
    step(0, 0, 0, 32'h0,        1, 32'hAA,  32'h1,  32'hAA, 32'h1,  1, 0, 1, 1);
    // flush during BOOT redirects
    step(1, 0, 0, 32'h0,        1, 32'h0,   32'h0,  32'h0,  32'h0,  0, 0, 0, 0);
    step(0, 0, 1, 32'h20,       1, 32'h0,   32'h20, 32'h0,  32'h0,  0, 0, 0, 1);
    // PC wrap from all-ones
    step(0, 0, 1, 32'hFFFFFFFF, 1, 32'h0,   32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 0, 2);
    step(0, 0, 0, 32'h0,        1, 32'hBB,  32'h0,  32'hBB, 32'h0,  1, 0, 1, 2);
    step(0, 0, 0, 32'h0,        1, 32'hCC,  32'h1,  32'hCC, 32'h1,  1, 0, 2, 2);

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
